// File: rtl/lfsr_checker.sv
// Serial checker for the 8-bit LFSR stream b[n] = b[n-8]^b[n-6]^b[n-3]^b[n-2].
// Hunts for lock on received bits, then flywheels its own prediction and counts errors.
module lfsr_checker #(
    parameter int unsigned LOCK_CNT  = 16,
    parameter int unsigned ERR_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        resync,
    input  logic        clear_cnt,
    input  logic        din_valid,
    input  logic        din,
    output logic        locked,
    output logic        err,
    output logic [15:0] err_cnt,
    output logic [15:0] bit_cnt
);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    localparam logic [7:0] LOCK_CNT_C  = 8'(LOCK_CNT);
    localparam logic [3:0] ERR_LIMIT_C = 4'(ERR_LIMIT);
    localparam logic [3:0] FILL_FULL   = 4'd8;
    localparam logic [3:0] RUN_CLEAR   = 4'd8;

    state_e      state_q, state_d;
    logic [7:0]  h_q, h_d;
    logic [3:0]  fill_q, fill_d;
    logic [7:0]  match_q, match_d;
    logic [3:0]  miss_q, miss_d;
    logic [3:0]  run_q, run_d;
    logic        err_q, err_d;
    logic [15:0] err_cnt_q, err_cnt_d;
    logic [15:0] bit_cnt_q, bit_cnt_d;

    logic predicted;
    logic mismatch;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // h[0] is b[n-8], h[2] is b[n-6], h[5] is b[n-3], h[6] is b[n-2].
    assign predicted = h_q[0] ^ h_q[2] ^ h_q[5] ^ h_q[6];
    assign mismatch  = (din != predicted);

    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        state_d   = state_q;
        h_d       = h_q;
        fill_d    = fill_q;
        match_d   = match_q;
        miss_d    = miss_q;
        run_d     = run_q;
        err_d     = 1'b0;
        // Clear happens first so a counted event in the same cycle lands on 1.
        err_cnt_d = clear_cnt ? 16'h0000 : err_cnt_q;
        bit_cnt_d = clear_cnt ? 16'h0000 : bit_cnt_q;

        if (resync) begin
            state_d = HUNT;
            h_d     = 8'h00;
            fill_d  = 4'd0;
            match_d = 8'd0;
            miss_d  = 4'd0;
            run_d   = 4'd0;
        end else if (din_valid) begin
            unique case (state_q)
                HUNT: begin
                    h_d = {din, h_q[7:1]};
                    if (fill_q != FILL_FULL) begin
                        fill_d = fill_q + 4'd1;
                    end else if (!mismatch && (h_q != 8'h00)) begin
                        match_d = match_q + 8'd1;
                        if (match_d == LOCK_CNT_C) begin
                            state_d = LOCKED;
                            miss_d  = 4'd0;
                            run_d   = 4'd0;
                        end
                    end else begin
                        match_d = 8'd0;
                    end
                end
                LOCKED: begin
                    // Flywheel: the prediction, not the received bit, enters history.
                    h_d       = {predicted, h_q[7:1]};
                    bit_cnt_d = sat_inc(bit_cnt_d);
                    if (mismatch) begin
                        err_d     = 1'b1;
                        err_cnt_d = sat_inc(err_cnt_d);
                        miss_d    = miss_q + 4'd1;
                        run_d     = 4'd0;
                        if (miss_d == ERR_LIMIT_C) begin
                            state_d = HUNT;
                            fill_d  = 4'd0;
                            match_d = 8'd0;
                        end
                    end else begin
                        run_d = (run_q == RUN_CLEAR) ? run_q : run_q + 4'd1;
                        if (run_d == RUN_CLEAR) begin
                            miss_d = 4'd0;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge only, so it lives inside the clocked branch.
        if (!reset) begin
            state_q   <= HUNT;
            h_q       <= 8'h00;
            fill_q    <= 4'd0;
            match_q   <= 8'd0;
            miss_q    <= 4'd0;
            run_q     <= 4'd0;
            err_q     <= 1'b0;
            err_cnt_q <= 16'h0000;
            bit_cnt_q <= 16'h0000;
        end else begin
            // NOTE: non-blocking assignments so all registers update from pre-edge values.
            state_q   <= state_d;
            h_q       <= h_d;
            fill_q    <= fill_d;
            match_q   <= match_d;
            miss_q    <= miss_d;
            run_q     <= run_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign locked  = (state_q == LOCKED);
    assign err     = err_q;
    assign err_cnt = err_cnt_q;
    assign bit_cnt = bit_cnt_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: directed scenarios plus a randomized soak, every cycle
// compared against a queue-based reference model of the hunt/lock behaviour.
module tb_lfsr_checker;

    localparam int LOCK_CNT  = 16;
    localparam int ERR_LIMIT = 4;
    localparam logic [7:0] SEED = 8'h80;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        resync = 1'b0;
    logic        clear_cnt = 1'b0;
    logic        din_valid = 1'b0;
    logic        din = 1'b0;
    logic        locked;
    logic        err;
    logic [15:0] err_cnt;
    logic [15:0] bit_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    lfsr_checker #(
        .LOCK_CNT (LOCK_CNT),
        .ERR_LIMIT(ERR_LIMIT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .resync   (resync),
        .clear_cnt(clear_cnt),
        .din_valid(din_valid),
        .din      (din),
        .locked   (locked),
        .err      (err),
        .err_cnt  (err_cnt),
        .bit_cnt  (bit_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Transmitter: first 8 bits are the seed LSB-first, then the recurrence.
    bit tx_bits[$];

    task automatic tx_bit(output logic b);
        int n;
        logic [7:0] seed_v;
        seed_v = SEED;
        n = tx_bits.size();
        if (n < 8) b = seed_v[n];
        else b = tx_bits[n-8] ^ tx_bits[n-6] ^ tx_bits[n-3] ^ tx_bits[n-2];
        tx_bits.push_back(b);
    endtask

    // Reference model: last-8-bit window as a queue, counts as plain integers.
    bit m_hist[$];
    bit m_locked = 1'b0;
    bit m_err = 1'b0;
    int m_match = 0;
    int m_miss = 0;
    int m_run = 0;
    int m_errc = 0;
    int m_bitc = 0;

    function automatic bit m_lag(input int k);
        return m_hist[8 - k];
    endfunction

    function automatic bit m_predict();
        return m_lag(8) ^ m_lag(6) ^ m_lag(3) ^ m_lag(2);
    endfunction

    function automatic bit m_window_nonzero();
        foreach (m_hist[i]) if (m_hist[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_step(input logic rst_n, input logic rs, input logic clr,
                              input logic dv, input logic d);
        bit p;
        m_err = 1'b0;
        if (!rst_n) begin
            m_locked = 1'b0;
            m_hist.delete();
            m_match = 0; m_miss = 0; m_run = 0; m_errc = 0; m_bitc = 0;
            return;
        end
        if (clr) begin
            m_errc = 0;
            m_bitc = 0;
        end
        if (rs) begin
            m_locked = 1'b0;
            m_hist.delete();
            m_match = 0; m_miss = 0; m_run = 0;
            return;
        end
        if (!dv) return;
        if (!m_locked) begin
            if (m_hist.size() == 8) begin
                p = m_predict();
                if ((d == p) && m_window_nonzero()) m_match++;
                else m_match = 0;
                void'(m_hist.pop_front());
            end
            m_hist.push_back(d);
            if (m_match == LOCK_CNT) begin
                m_locked = 1'b1;
                m_match = 0; m_miss = 0; m_run = 0;
            end
        end else begin
            p = m_predict();
            void'(m_hist.pop_front());
            m_hist.push_back(p);
            m_bitc = (m_bitc < 65535) ? m_bitc + 1 : 65535;
            if (d != p) begin
                m_err = 1'b1;
                m_errc = (m_errc < 65535) ? m_errc + 1 : 65535;
                m_miss++;
                m_run = 0;
                if (m_miss == ERR_LIMIT) begin
                    m_locked = 1'b0;
                    m_hist.delete();
                    m_match = 0;
                end
            end else begin
                m_run++;
                if (m_run >= 8) m_miss = 0;
            end
        end
    endtask

    task automatic cycle(input logic rst_n, input logic rs, input logic clr,
                         input logic dv, input logic d);
        @(negedge clk);
        reset = rst_n; resync = rs; clear_cnt = clr; din_valid = dv; din = d;
        @(posedge clk);
        model_step(rst_n, rs, clr, dv, d);
        #1;
        check("locked", locked, m_locked);
        check("err", err, m_err);
        check("err_cnt", err_cnt, m_errc);
        check("bit_cnt", bit_cnt, m_bitc);
    endtask

    task automatic send_tx(input logic flip);
        logic b;
        tx_bit(b);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, b ^ flip);
    endtask

    task automatic idle(input logic clr);
        cycle(1'b1, 1'b0, clr, 1'b0, 1'b0);
    endtask

    initial begin
        logic b;
        int   err_seen;
        int   lock_seen;
        int   vb;

        // Reset state.
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        check("rst_locked", locked, 0);
        check("rst_err_cnt", err_cnt, 0);

        // Clean stream from seed: lock exactly at the 24th bit.
        err_seen = 0;
        for (int i = 1; i <= 24; i++) begin
            send_tx(1'b0);
            err_seen += int'(err);
            if (i == 23) check("pre_lock_23", locked, 0);
            if (i == 24) check("lock_at_24", locked, 1);
        end
        for (int i = 0; i < 20; i++) begin
            send_tx(1'b0);
            err_seen += int'(err);
        end
        check("bit_cnt_20", bit_cnt, 20);
        check("clean_err_pulses", err_seen, 0);

        // Single inverted bit: one err pulse, flywheel keeps later bits clean.
        send_tx(1'b1);
        check("single_err_pulse", err, 1);
        check("single_err_cnt", err_cnt, 1);
        check("single_still_locked", locked, 1);
        send_tx(1'b0);
        check("single_err_drops", err, 0);
        err_seen = 0;
        for (int i = 0; i < 30; i++) begin
            send_tx(1'b0);
            err_seen += int'(err);
        end
        check("no_err_multiplication", err_seen, 0);

        // Four errors two bits apart: lock drops, relock after 24 clean bits.
        idle(1'b1);
        for (int j = 0; j <= 6; j++) begin
            send_tx((j % 2) == 0);
            if (j == 4) check("still_locked_3_err", locked, 1);
        end
        check("dense_err_cnt", err_cnt, 4);
        check("dense_unlock", locked, 0);
        for (int i = 1; i <= 24; i++) begin
            send_tx(1'b0);
            if (i == 23) check("relock_pre_23", locked, 0);
            if (i == 24) check("relock_at_24", locked, 1);
        end

        // Four errors ten bits apart: lock survives.
        idle(1'b1);
        for (int j = 0; j <= 30; j++) send_tx((j % 10) == 0);
        check("sparse_err_cnt", err_cnt, 4);
        check("sparse_locked", locked, 1);

        // resync + clear_cnt mid-lock, bit in that cycle discarded.
        tx_bit(b);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, b);
        check("resync_unlock", locked, 0);
        check("resync_err_cnt", err_cnt, 0);
        check("resync_bit_cnt", bit_cnt, 0);

        // Relock with random din_valid gaps: still 24 valid bits.
        vb = 0;
        for (int k = 0; k < 400 && vb < 24; k++) begin
            if ($urandom_range(2) == 0) idle(1'b0);
            else begin
                send_tx(1'b0);
                vb++;
                if (vb == 23) check("gap_pre_lock", locked, 0);
            end
        end
        check("gap_valid_bits", vb, 24);
        check("gap_lock", locked, 1);

        // clear_cnt with a simultaneous counted event ends at 1; without, at 0.
        tx_bit(b);
        cycle(1'b1, 1'b0, 1'b1, 1'b1, ~b);
        check("clr_evt_err_cnt", err_cnt, 1);
        check("clr_evt_bit_cnt", bit_cnt, 1);
        idle(1'b1);
        check("clr_idle_err_cnt", err_cnt, 0);
        send_tx(1'b0);

        // Reset mid-lock overrides everything.
        tx_bit(b);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, b);
        check("midrst_locked", locked, 0);
        check("midrst_err", err, 0);
        check("midrst_bit_cnt", bit_cnt, 0);

        // All-zero stream never locks.
        lock_seen = 0;
        for (int i = 0; i < 100; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
            lock_seen += int'(locked);
        end
        check("zeros_lock_seen", lock_seen, 0);
        check("zeros_err_cnt", err_cnt, 0);

        // Pure random bits.
        for (int i = 0; i < 300; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)));
        end

        // Random soak over the transmitter stream.
        for (int i = 0; i < 3000; i++) begin
            logic rst_n, rs, clr, dv, fl;
            rst_n = ($urandom_range(999) != 0);
            rs    = ($urandom_range(499) == 0);
            clr   = ($urandom_range(299) == 0);
            dv    = ($urandom_range(3) != 0);
            fl    = ($urandom_range(39) == 0);
            if (dv) tx_bit(b);
            else b = 1'b0;
            cycle(rst_n, rs, clr, dv, b ^ fl);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
